// File: rtl/crono_if.sv
// crono_if: chronometer command bus between the control FSM (master) and the countdown timer (slave).
interface crono_if;
    logic       WR_inistop;
    logic [2:0] inistop;
    logic [7:0] dir;
    logic       preset_load;
    logic [7:0] preset_hh;
    logic [7:0] preset_mm;
    logic [7:0] preset_ss;
    logic       crono_end;
    logic       running;
    logic       load_err;
    logic [7:0] cnt_hh;
    logic [7:0] cnt_mm;
    logic [7:0] cnt_ss;
    modport master (
        output WR_inistop, inistop, dir, preset_load, preset_hh, preset_mm, preset_ss,
        input  crono_end, running, load_err, cnt_hh, cnt_mm, cnt_ss
    );
    modport slave (
        input  WR_inistop, inistop, dir, preset_load, preset_hh, preset_mm, preset_ss,
        output crono_end, running, load_err, cnt_hh, cnt_mm, cnt_ss
    );
endinterface

// File: rtl/crono_timer.sv
// crono_timer: BCD HH:MM:SS countdown that answers start/stop commands and flags expiry on crono_end.
module crono_timer #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter logic [7:0]  ADDR     = 8'h00
) (
    input logic   clk,
    input logic   reset,
    crono_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [23:0]   preset;
    logic [23:0]   count;
    logic [23:0]   dec;
    logic [PW-1:0] presc;
    logic          wr_q;
    logic          crono_end;
    logic          running;
    logic          load_err;
    logic          cmd_stb;
    logic          start;
    logic          stop;
    logic          tick;
    logic          load_ok;

    function automatic logic [7:0] dec_bcd(input logic [7:0] v, input logic [7:0] wrap);
        return (v == 8'h00) ? wrap : (v[3:0] == 4'h0) ? {v[7:4] - 4'd1, 4'h9} : v - 8'd1;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    assign cmd_stb = bus.WR_inistop & ~wr_q & (bus.dir == ADDR);
    assign start   = cmd_stb & (bus.inistop == 3'b101);
    assign stop    = cmd_stb & (bus.inistop == 3'b110);
    assign tick    = presc == PW'(TICK_DIV - 1);
    assign load_ok = bcd_ok(bus.preset_hh, 8'h23) && bcd_ok(bus.preset_mm, 8'h59) && bcd_ok(bus.preset_ss, 8'h59);
    // Borrows ripple only through fields that are already zero
    assign dec[7:0]   = dec_bcd(count[7:0], 8'h59);
    assign dec[15:8]  = (count[7:0] == 8'h00) ? dec_bcd(count[15:8], 8'h59) : count[15:8];
    assign dec[23:16] = (count[15:0] == 16'h0000) ? dec_bcd(count[23:16], 8'h23) : count[23:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            preset    <= '0;
            count     <= '0;
            presc     <= '0;
            wr_q      <= 1'b1;
            crono_end <= 1'b0;
            running   <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wr_q     <= bus.WR_inistop;
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && preset == 24'h0) begin
                        state     <= DONE;
                        crono_end <= 1'b1;
                    end else if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        count   <= preset;
                        presc   <= '0;
                    end else if (bus.preset_load && !cmd_stb && load_ok) begin
                        preset <= {bus.preset_hh, bus.preset_mm, bus.preset_ss};
                        count  <= {bus.preset_hh, bus.preset_mm, bus.preset_ss};
                    end else if (bus.preset_load && !cmd_stb) begin
                        load_err <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        count   <= preset;
                        presc   <= '0;
                    end else if (start) begin
                        count <= preset;
                        presc <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        count <= dec;
                        if (dec == 24'h0) begin
                            state     <= DONE;
                            running   <= 1'b0;
                            crono_end <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                DONE: begin
                    if (stop) begin
                        state     <= IDLE;
                        crono_end <= 1'b0;
                        count     <= preset;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.crono_end = crono_end;
    assign bus.running   = running;
    assign bus.load_err  = load_err;
    assign bus.cnt_hh    = count[23:16];
    assign bus.cnt_mm    = count[15:8];
    assign bus.cnt_ss    = count[7:0];
endmodule

// File: tb/tb_crono_timer.sv
// tb_crono_timer: directed scenario tasks for crono_timer with TICK_DIV=4.
module tb_crono_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [23:0] cnt;

    crono_if bus ();
    crono_timer #(.TICK_DIV(4), .ADDR(8'h00)) dut (.clk(clk), .reset(reset), .bus(bus));

    assign cnt = {bus.cnt_hh, bus.cnt_mm, bus.cnt_ss};
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        bus.preset_load = 1'b1;
        bus.preset_hh = hh;
        bus.preset_mm = mm;
        bus.preset_ss = ss;
        step(1);
        bus.preset_load = 1'b0;
    endtask

    // One idle cycle keeps WR_inistop low so the next high level is a fresh rising edge
    task automatic cmd(input logic [2:0] code, input logic [7:0] addr);
        bus.WR_inistop = 1'b0;
        step(1);
        bus.WR_inistop = 1'b1;
        bus.inistop = code;
        bus.dir = addr;
        step(1);
        bus.WR_inistop = 1'b0;
        bus.dir = 8'h00;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        checks++; if ({cnt, bus.crono_end, bus.running, bus.load_err} !== 27'h0) begin failures++; $display("FAIL reset_outputs got cnt=%h end=%b run=%b err=%b exp all 0", cnt, bus.crono_end, bus.running, bus.load_err); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_hold_start;
        do_load(8'h00, 8'h00, 8'h03);
        checks++; if (cnt !== 24'h000003) begin failures++; $display("FAIL hold_mirror got=%h exp=000003", cnt); end
        bus.WR_inistop = 1'b1;
        bus.inistop = 3'b101;
        step(1);
        checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL hold_running got=%b exp=1", bus.running); end
        step(3);
        checks++; if (cnt !== 24'h000003) begin failures++; $display("FAIL hold_c3 got=%h exp=000003", cnt); end
        step(1);
        checks++; if (cnt !== 24'h000002) begin failures++; $display("FAIL hold_c4 got=%h exp=000002", cnt); end
        step(4);
        checks++; if (cnt !== 24'h000001) begin failures++; $display("FAIL hold_c8 got=%h exp=000001", cnt); end
        step(4);
        checks++; if ({cnt, bus.crono_end, bus.running} !== {24'h0, 2'b10}) begin failures++; $display("FAIL hold_c12 got cnt=%h end=%b run=%b exp 000000 1 0", cnt, bus.crono_end, bus.running); end
        step(500);
        checks++; if ({cnt, bus.crono_end, bus.running} !== {24'h0, 2'b10}) begin failures++; $display("FAIL hold_long got cnt=%h end=%b run=%b exp 000000 1 0", cnt, bus.crono_end, bus.running); end
        bus.WR_inistop = 1'b0;
        cmd(3'b110, 8'h00);
        checks++; if ({cnt, bus.crono_end} !== {24'h000003, 1'b0}) begin failures++; $display("FAIL hold_stop got cnt=%h end=%b exp 000003 0", cnt, bus.crono_end); end
    endtask

    task automatic test_borrow;
        do_load(8'h01, 8'h00, 8'h00);
        cmd(3'b101, 8'h00);
        step(4);
        checks++; if (cnt !== 24'h005959) begin failures++; $display("FAIL borrow_first got=%h exp=005959", cnt); end
        step(44);
        checks++; if (cnt !== 24'h005948) begin failures++; $display("FAIL borrow_nibble got=%h exp=005948", cnt); end
        step(4 * 3587);
        checks++; if ({cnt, bus.crono_end} !== {24'h000001, 1'b0}) begin failures++; $display("FAIL borrow_last1 got cnt=%h end=%b exp 000001 0", cnt, bus.crono_end); end
        step(4);
        checks++; if ({cnt, bus.crono_end, bus.running} !== {24'h0, 2'b10}) begin failures++; $display("FAIL borrow_expire got cnt=%h end=%b run=%b exp 000000 1 0", cnt, bus.crono_end, bus.running); end
        cmd(3'b110, 8'h00);
    endtask

    task automatic test_stop_done;
        do_load(8'h00, 8'h00, 8'h05);
        cmd(3'b101, 8'h00);
        step(16);
        checks++; if (cnt !== 24'h000001) begin failures++; $display("FAIL stop_pre got=%h exp=000001", cnt); end
        cmd(3'b110, 8'h00);
        checks++; if ({cnt, bus.crono_end, bus.running} !== {24'h000005, 2'b00}) begin failures++; $display("FAIL stop_run got cnt=%h end=%b run=%b exp 000005 0 0", cnt, bus.crono_end, bus.running); end
        step(8);
        checks++; if (cnt !== 24'h000005) begin failures++; $display("FAIL stop_idle_hold got=%h exp=000005", cnt); end
        cmd(3'b101, 8'h00);
        step(20);
        checks++; if ({cnt, bus.crono_end} !== {24'h0, 1'b1}) begin failures++; $display("FAIL done_reach got cnt=%h end=%b exp 000000 1", cnt, bus.crono_end); end
        cmd(3'b101, 8'h00);
        step(4);
        checks++; if ({cnt, bus.crono_end, bus.running} !== {24'h0, 2'b10}) begin failures++; $display("FAIL done_start got cnt=%h end=%b run=%b exp 000000 1 0", cnt, bus.crono_end, bus.running); end
        cmd(3'b110, 8'h00);
        checks++; if ({cnt, bus.crono_end} !== {24'h000005, 1'b0}) begin failures++; $display("FAIL done_stop got cnt=%h end=%b exp 000005 0", cnt, bus.crono_end); end
    endtask

    task automatic test_invalid_load;
        do_load(8'h00, 8'h60, 8'h00);
        checks++; if ({bus.load_err, cnt} !== {1'b1, 24'h000005}) begin failures++; $display("FAIL bad_mm got err=%b cnt=%h exp 1 000005", bus.load_err, cnt); end
        step(1);
        checks++; if (bus.load_err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", bus.load_err); end
        do_load(8'h00, 8'h00, 8'h0A);
        checks++; if ({bus.load_err, cnt} !== {1'b1, 24'h000005}) begin failures++; $display("FAIL bad_ss got err=%b cnt=%h exp 1 000005", bus.load_err, cnt); end
        do_load(8'h24, 8'h00, 8'h00);
        checks++; if ({bus.load_err, cnt} !== {1'b1, 24'h000005}) begin failures++; $display("FAIL bad_hh got err=%b cnt=%h exp 1 000005", bus.load_err, cnt); end
        do_load(8'h23, 8'h59, 8'h59);
        checks++; if ({bus.load_err, cnt} !== {1'b0, 24'h235959}) begin failures++; $display("FAIL max_ok got err=%b cnt=%h exp 0 235959", bus.load_err, cnt); end
        do_load(8'h00, 8'h00, 8'h05);
        cmd(3'b101, 8'h00);
        do_load(8'h00, 8'h00, 8'h09);
        checks++; if ({bus.load_err, bus.running} !== 2'b01) begin failures++; $display("FAIL run_load got err=%b run=%b exp 0 1", bus.load_err, bus.running); end
        cmd(3'b110, 8'h00);
        checks++; if (cnt !== 24'h000005) begin failures++; $display("FAIL run_load_kept got=%h exp=000005", cnt); end
    endtask

    task automatic test_zero_and_filter;
        do_load(8'h00, 8'h00, 8'h00);
        cmd(3'b101, 8'h01);
        checks++; if ({bus.crono_end, bus.running} !== 2'b00) begin failures++; $display("FAIL bad_dir got end=%b run=%b exp 0 0", bus.crono_end, bus.running); end
        cmd(3'b011, 8'h00);
        checks++; if ({bus.crono_end, bus.running} !== 2'b00) begin failures++; $display("FAIL bad_code got end=%b run=%b exp 0 0", bus.crono_end, bus.running); end
        cmd(3'b101, 8'h00);
        checks++; if ({bus.crono_end, bus.running, cnt} !== {2'b10, 24'h0}) begin failures++; $display("FAIL zero_start got end=%b run=%b cnt=%h exp 1 0 000000", bus.crono_end, bus.running, cnt); end
        cmd(3'b110, 8'h00);
        bus.WR_inistop = 1'b0;
        step(1);
        bus.WR_inistop = 1'b1;
        bus.inistop = 3'b101;
        bus.preset_load = 1'b1;
        bus.preset_ss = 8'h07;
        step(1);
        bus.WR_inistop = 1'b0;
        bus.preset_load = 1'b0;
        checks++; if ({bus.crono_end, bus.load_err, cnt} !== {2'b10, 24'h0}) begin failures++; $display("FAIL cmd_wins got end=%b err=%b cnt=%h exp 1 0 000000", bus.crono_end, bus.load_err, cnt); end
        cmd(3'b110, 8'h00);
        checks++; if (cnt !== 24'h0) begin failures++; $display("FAIL cmd_wins_preset got=%h exp=000000", cnt); end
    endtask

    task automatic test_reset_mid_run;
        do_load(8'h00, 8'h00, 8'h05);
        cmd(3'b101, 8'h00);
        step(5);
        bus.WR_inistop = 1'b1;
        bus.inistop = 3'b101;
        reset = 1'b1;
        #1;
        checks++; if ({cnt, bus.crono_end, bus.running, bus.load_err} !== 27'h0) begin failures++; $display("FAIL async_reset got cnt=%h end=%b run=%b err=%b exp all 0", cnt, bus.crono_end, bus.running, bus.load_err); end
        step(2);
        reset = 1'b0;
        step(3);
        checks++; if ({cnt, bus.crono_end, bus.running} !== 26'h0) begin failures++; $display("FAIL held_wr got cnt=%h end=%b run=%b exp 000000 0 0", cnt, bus.crono_end, bus.running); end
        bus.WR_inistop = 1'b0;
        do_load(8'h00, 8'h00, 8'h02);
        cmd(3'b101, 8'h00);
        checks++; if ({bus.running, cnt} !== {1'b1, 24'h000002}) begin failures++; $display("FAIL post_reset_cmd got run=%b cnt=%h exp 1 000002", bus.running, cnt); end
    endtask

    initial begin
        bus.WR_inistop = 1'b0;
        bus.inistop = 3'b000;
        bus.dir = 8'h00;
        bus.preset_load = 1'b0;
        bus.preset_hh = 8'h00;
        bus.preset_mm = 8'h00;
        bus.preset_ss = 8'h00;
        test_reset;
        test_hold_start;
        test_borrow;
        test_stop_done;
        test_invalid_load;
        test_zero_and_filter;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crono_timer.md
Name: crono_timer

Overview:
- Responder end of the chronometer command interface.
- Accepts start/stop write strobes (WR_inistop, inistop, dir) from the chronometer control FSM.
- Runs a BCD HH:MM:SS countdown from a loaded preset and raises crono_end when the count reaches 00:00:00.
- Sits beside the control FSM and feeds its crono_end input; count outputs go to the display path.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second decrement; minimum 2.
- ADDR, 8'h00: dir value this block responds to.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- WR_inistop  input  1  command write enable; may stay high for many cycles.
- inistop  input  3  command code: 3'b101 start, 3'b110 stop; all other codes ignored.
- dir  input  8  command address; a command is accepted only when dir==ADDR.
- preset_load  input  1  one-cycle request to latch the preset fields.
- preset_hh  input  8  BCD hours, 00-23.
- preset_mm  input  8  BCD minutes, 00-59.
- preset_ss  input  8  BCD seconds, 00-59.
- crono_end  output  1  countdown expired; level signal.
- running  output  1  high while in RUN.
- load_err  output  1  one-cycle pulse when preset_load is rejected.
- cnt_hh  output  8  current BCD hours.
- cnt_mm  output  8  current BCD minutes.
- cnt_ss  output  8  current BCD seconds.

Behaviour:
- All outputs are registered. Reset is asynchronous.
- Reset values:
  - state=IDLE; preset=00:00:00; count=00:00:00; prescaler=0.
  - crono_end=0; running=0; load_err=0.
  - wr_q=1, so a WR_inistop held high across reset release is not taken as a command.
- Command strobe:
  - cmd_stb = WR_inistop & ~wr_q & (dir==ADDR); wr_q <= WR_inistop every cycle.
  - One command is accepted per WR_inistop rising edge, however long the level is held.
  - Latency: the state change and output update occur at the same edge that samples the strobe.
- States: IDLE, RUN, DONE.
- IDLE:
  - count mirrors the preset; running=0; crono_end=0.
  - Start: if preset==00:00:00, go to DONE (crono_end=1). Otherwise go to RUN, with count=preset and prescaler=0.
  - Stop: no effect.
  - preset_load is honoured only in IDLE.
    - Each field is validated: both nibbles <=9, ss<=0x59, mm<=0x59, hh<=0x23.
    - Valid: all three fields latch at the next edge.
    - Any field invalid: preset is unchanged and load_err pulses for 1 cycle.
  - Simultaneous cmd_stb and preset_load: the command wins; preset_load is dropped, with no load_err. Start then uses the old preset.
- RUN:
  - running=1.
  - Prescaler counts 0..TICK_DIV-1. On its wrap, the count decrements by one second:
    - ss low nibble 0 borrows from the high nibble.
    - ss 00 goes to 59 and borrows from mm; mm 00 goes to 59 and borrows from hh.
    - hh never underflows, because expiry is caught first.
  - Expiry: if a decrement yields 00:00:00, go to DONE on that same edge. crono_end=1 and running=0 are visible together with count 00:00:00.
  - Stop: go to IDLE; count reloads from the preset; prescaler=0; crono_end stays 0.
  - Start: restart; count reloads from the preset; prescaler=0; stays in RUN.
  - Stop and tick on the same edge: stop wins, with no decrement.
  - preset_load is ignored, with no load_err.
- DONE:
  - crono_end=1; count holds 00:00:00; running=0.
  - Stop: go to IDLE; crono_end=0 from that edge; count shows the preset.
  - Start is ignored. preset_load is ignored.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the preset is also cleared.
- Commands with other inistop codes, or with dir!=ADDR, have no effect but still update wr_q.

Test Plan (bench TICK_DIV=4):
- Reset, then preset_load 00:00:03 and start; hold WR_inistop high for 512 cycles.
  - Required: running=1 from the start edge.
  - Required: count 02, 01, 00 at cycles 4, 8 and 12 after the start edge.
  - Required: crono_end=1 on the edge that count reaches 00; only one start is accepted.
- Borrow chain: preset 01:00:00, start, one tick.
  - Required: count 00:59:59; after 3599 more ticks, crono_end=1.
- Stop in RUN at count 00:00:01 (preset 00:00:05).
  - Required: IDLE, count=00:00:05, crono_end stays 0.
  - Required: start in DONE ignored; stop in DONE gives crono_end=0 next edge.
- Invalid preset_load of 00:60:00 or 0x0A seconds.
  - Required: load_err one-cycle pulse, preset unchanged.
  - Required: preset_load during RUN ignored, no load_err.
- Start with preset 00:00:00 -> DONE at the strobe edge, crono_end=1.
  - Required: start with dir=8'h01 or inistop=3'b011 -> no state change.
- Assert reset mid-RUN while WR_inistop is high, then release.
  - Required: all outputs at reset values and no command taken.
  - Required: the next WR_inistop rising edge is accepted.
